id_operand_stage: RTL and testbench

ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

---
 rtl/id_operand_stage_pkg.sv | 22 ++
 rtl/id_operand_stage_regfile.sv | 26 ++
 rtl/id_operand_stage.sv | 164 ++++++++++++++++
 tb/tb_id_operand_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_operand_stage_pkg.sv
// Shared widths and the slot payload type for the decode/operand stage.
package id_operand_stage_pkg;

  localparam int REG_AW   = 5;   // register address width
  localparam int XLEN     = 32;  // data width
  localparam int NUM_REGS = 32;  // architectural registers, r0 hard-wired to 0
  localparam int PEND_W   = 3;   // load-pending counter width (holds LOAD_LAT up to 7)

  // Everything the stage latches for one instruction.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst;
    logic [REG_AW-1:0] raddr1;
    logic [REG_AW-1:0] raddr2;
    logic              use1;
    logic              use2;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic              is_load;
  } slot_t;

endpackage

// File: rtl/id_operand_stage_regfile.sv
// 2-read / 1-write register file: asynchronous reads, write at posedge,
// contents not reset, r0 always reads zero.
module regfile
  import id_operand_stage_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o
);

  logic [XLEN-1:0] mem_q [NUM_REGS];

  // Write port; r0 is never stored so it needs no reset.
  always_ff @(posedge clk) begin
    if (we_i && waddr_i != '0) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/id_operand_stage.sv
// Decode operand stage: one-entry slot, load-use interlock via per-register
// pending counters, operand forwarding (fwd sources, then WB, then regfile).
// Optional feature: define ID_STALL_CNT_EN to add the stall_cnt output.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int NUM_FWD  = 3,
  parameter int LOAD_LAT = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [XLEN-1:0]                  in_pc,
  input  logic [XLEN-1:0]                  in_inst,
  input  logic [REG_AW-1:0]                in_raddr1,
  input  logic [REG_AW-1:0]                in_raddr2,
  input  logic                             in_use1,
  input  logic                             in_use2,
  input  logic                             in_wr_en,
  input  logic [REG_AW-1:0]                in_wr_addr,
  input  logic                             in_is_load,
  input  logic [NUM_FWD-1:0]               fwd_we,
  input  logic [NUM_FWD-1:0][REG_AW-1:0]   fwd_waddr,
  input  logic [NUM_FWD-1:0][XLEN-1:0]     fwd_wdata,
  input  logic                             wb_we,
  input  logic [REG_AW-1:0]                wb_waddr,
  input  logic [XLEN-1:0]                  wb_wdata,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [XLEN-1:0]                  out_pc,
  output logic [XLEN-1:0]                  out_inst,
  output logic [XLEN-1:0]                  out_rdata1,
  output logic [XLEN-1:0]                  out_rdata2,
  output logic                             out_wr_en,
  output logic [REG_AW-1:0]                out_wr_addr,
  output logic                             out_is_load,
  output logic                             stallreq
`ifdef ID_STALL_CNT_EN
  ,
  output logic [XLEN-1:0]                  stall_cnt
`endif
);

  slot_t slot_q, slot_d;
  logic  slot_vld_q, slot_vld_d;

  logic                in_fire, out_fire, hazard, load_set;
  logic [NUM_REGS-1:0] busy;
  logic [XLEN-1:0]     rf_rdata1, rf_rdata2;

  assign out_fire = out_valid & out_ready;
  assign in_ready = ~slot_vld_q | out_fire;
  assign in_fire  = in_valid & in_ready;

  // A load leaving the stage blocks its destination for LOAD_LAT cycles.
  assign load_set = out_fire & slot_q.is_load & slot_q.wr_en & (slot_q.wr_addr != '0);

  // Per-register pending counters; r0 never blocks.
  assign busy[0] = 1'b0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
    logic [PEND_W-1:0] pend_q;
    // Reload on a departing load to this register, otherwise count down to 0.
    always_ff @(posedge clk) begin
      if (rst)                                                pend_q <= '0;
      else if (load_set && slot_q.wr_addr == REG_AW'(r))     pend_q <= PEND_W'(LOAD_LAT);
      else if (pend_q != '0)                                  pend_q <= pend_q - 1'b1;
    end
    assign busy[r] = (pend_q != '0);
  end

  assign hazard = slot_vld_q & ((slot_q.use1 & busy[slot_q.raddr1]) |
                                (slot_q.use2 & busy[slot_q.raddr2]));

  assign out_valid = slot_vld_q & ~hazard;
  assign stallreq  = hazard;

  // Slot next state: flush beats a new fire, a drain without refill empties it.
  always_comb begin
    slot_d     = slot_q;
    slot_vld_d = slot_vld_q;
    if (flush) begin
      slot_d     = '0;
      slot_vld_d = 1'b0;
    end else if (in_fire) begin
      slot_d.pc      = in_pc;
      slot_d.inst    = in_inst;
      slot_d.raddr1  = in_raddr1;
      slot_d.raddr2  = in_raddr2;
      slot_d.use1    = in_use1;
      slot_d.use2    = in_use2;
      slot_d.wr_en   = in_wr_en;
      slot_d.wr_addr = in_wr_addr;
      slot_d.is_load = in_is_load;
      slot_vld_d     = 1'b1;
    end else if (out_fire) begin
      slot_vld_d = 1'b0;
    end
  end

  // Slot register.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q     <= '0;
      slot_vld_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      slot_vld_q <= slot_vld_d;
    end
  end

  regfile u_rf (
    .clk      (clk),
    .we_i     (wb_we),
    .waddr_i  (wb_waddr),
    .wdata_i  (wb_wdata),
    .raddr1_i (slot_q.raddr1),
    .raddr2_i (slot_q.raddr2),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2)
  );

  // Youngest matching forward source wins, then the WB port, then the regfile.
  function automatic logic [XLEN-1:0] pick(input logic [REG_AW-1:0] ra,
                                           input logic [XLEN-1:0]   rf);
    logic [XLEN-1:0] v;
    logic            hit;
    v   = rf;
    hit = 1'b0;
    if (wb_we && wb_waddr == ra) v = wb_wdata;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && fwd_we[i] && fwd_waddr[i] == ra) begin
        v   = fwd_wdata[i];
        hit = 1'b1;
      end
    end
    if (ra == '0) v = '0;
    return v;
  endfunction

  // Operand mux, combinational from the slot's read addresses.
  always_comb begin
    out_rdata1 = pick(slot_q.raddr1, rf_rdata1);
    out_rdata2 = pick(slot_q.raddr2, rf_rdata2);
  end

  assign out_pc      = slot_q.pc;
  assign out_inst    = slot_q.inst;
  assign out_wr_en   = slot_q.wr_en;
  assign out_wr_addr = slot_q.wr_addr;
  assign out_is_load = slot_q.is_load;

`ifdef ID_STALL_CNT_EN
  logic [XLEN-1:0] stall_cnt_q;
  // Interlock cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)         stall_cnt_q <= '0;
    else if (hazard) stall_cnt_q <= stall_cnt_q + 1'b1;
  end
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: cycle model compared every cycle plus directed
// literal checks for reset, load-use, forwarding, backpressure and flush.
module tb_id_operand_stage;

  localparam int NUM_FWD  = 3;
  localparam int LOAD_LAT = 2;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic [4:0]  in_raddr1, in_raddr2, in_wr_addr;
  logic        in_use1, in_use2, in_wr_en, in_is_load;
  logic [NUM_FWD-1:0]       fwd_we;
  logic [NUM_FWD-1:0][4:0]  fwd_waddr;
  logic [NUM_FWD-1:0][31:0] fwd_wdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        out_valid, out_ready, out_wr_en, out_is_load, stallreq;
  logic [31:0] out_pc, out_inst, out_rdata1, out_rdata2;
  logic [4:0]  out_wr_addr;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  id_operand_stage #(.NUM_FWD(NUM_FWD), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_raddr1(in_raddr1), .in_raddr2(in_raddr2),
    .in_use1(in_use1), .in_use2(in_use2), .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr),
    .in_is_load(in_is_load), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_rdata1(out_rdata1),
    .out_rdata2(out_rdata2), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
    .out_is_load(out_is_load), .stallreq(stallreq)
`ifdef ID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic        vld;
    logic [31:0] pc, inst;
    logic [4:0]  ra1, ra2;
    logic        u1, u2, we;
    logic [4:0]  wa;
    logic        ld;
  } mslot_t;

  mslot_t      m;
  logic [31:0] regs [32];
  longint      ready_cyc [32];  // first cycle a register may be read again
  longint      cyc = 0;
  logic [31:0] m_stalls;

  initial begin
    m = '0;
    m_stalls = '0;
    for (int i = 0; i < 32; i++) begin regs[i] = '0; ready_cyc[i] = 0; end
  end

  function automatic bit busy(input logic [4:0] r);
    return (r != 0) && (cyc < ready_cyc[r]);
  endfunction

  function automatic logic [31:0] resolve(input logic [4:0] r);
    if (r == 0) return 32'h0;
    for (int i = 0; i < NUM_FWD; i++)
      if (fwd_we[i] && fwd_waddr[i] == r) return fwd_wdata[i];
    if (wb_we && wb_waddr == r) return wb_wdata;
    return regs[r];
  endfunction

  // Compare on negedge, then advance the model with the inputs held until posedge.
  always @(negedge clk) begin
    bit haz, ov, fire;
    haz  = m.vld && ((m.u1 && busy(m.ra1)) || (m.u2 && busy(m.ra2)));
    ov   = m.vld && !haz;
    fire = ov && out_ready;
    if (chk_en) begin
      chk("out_valid", out_valid, ov);
      chk("stallreq", stallreq, haz);
      chk("in_ready", in_ready, !m.vld || fire);
      chk("out_pc", out_pc, m.pc);
      chk("out_inst", out_inst, m.inst);
      chk("out_wr_en", out_wr_en, m.we);
      chk("out_wr_addr", out_wr_addr, m.wa);
      chk("out_is_load", out_is_load, m.ld);
      if (ov) begin
        chk("out_rdata1", out_rdata1, resolve(m.ra1));
        chk("out_rdata2", out_rdata2, resolve(m.ra2));
      end
`ifdef ID_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stalls);
`endif
    end
    if (wb_we && wb_waddr != 0) regs[wb_waddr] = wb_wdata;
    if (rst) begin
      m = '0;
      m_stalls = '0;
      for (int i = 0; i < 32; i++) ready_cyc[i] = 0;
    end else begin
      if (haz) m_stalls = m_stalls + 1;
      if (fire && m.ld && m.we && m.wa != 0) ready_cyc[m.wa] = cyc + LOAD_LAT + 1;
      if (flush) m = '0;
      else if (!m.vld || fire) begin
        if (in_valid) m = '{1'b1, in_pc, in_inst, in_raddr1, in_raddr2,
                            in_use1, in_use2, in_wr_en, in_wr_addr, in_is_load};
        else m.vld = 1'b0;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_inst(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2, input logic we,
                          input logic [4:0] wa, input logic ld);
    in_pc = pc; in_inst = pc ^ 32'h5A5A_0000;
    in_raddr1 = r1; in_raddr2 = r2; in_use1 = u1; in_use2 = u2;
    in_wr_en = we; in_wr_addr = wa; in_is_load = ld;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_inst(32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;

    // Reset
    tick(); tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_stallreq", stallreq, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_pc", out_pc, 32'h0);
`ifdef ID_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'h0);
`endif
    tick();
    rst = 1'b0;

    // Fill the register file with r -> 0xA000_0000 | r
    for (int r = 1; r < 32; r++) begin
      wb_we = 1'b1; wb_waddr = 5'(r); wb_wdata = 32'hA000_0000 | 32'(r);
      tick();
    end
    wb_we = 1'b0;

    // Plain pass-through from the regfile
    set_inst(32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("basic_valid", out_valid, 1'b1);
    chk("basic_rdata1", out_rdata1, 32'hA000_0001);
    chk("basic_rdata2", out_rdata2, 32'hA000_0002);
    chk("basic_pc", out_pc, 32'h100);
    tick();

    // Back-to-back stream, no bubbles expected
    for (int k = 0; k < 4; k++) begin
      set_inst(32'h200 + 32'(4*k), 5'(k + 10), 5'(k + 20), 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Load-use: load r5 leaves at c1, consumer stalls c2,c3, issues c4
    set_inst(32'h300, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);
    in_valid = 1'b1;
    tick();
    set_inst(32'h304, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lu_stall_t1", stallreq, 1'b1);
    chk("lu_valid_t1", out_valid, 1'b0);
    chk("lu_inready_t1", in_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("lu_stall_t2", stallreq, 1'b1);
    tick();
    fwd_we = 3'b010; fwd_waddr[1] = 5'd5; fwd_wdata[1] = 32'h55;
    @(negedge clk);
    chk("lu_valid_t3", out_valid, 1'b1);
    chk("lu_stall_t3", stallreq, 1'b0);
    chk("lu_fwd_data", out_rdata1, 32'h55);
    tick();
    fwd_we = '0;

    // Forward priority and r0
    set_inst(32'h400, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    fwd_we = 3'b111;
    fwd_waddr[0] = 5'd7; fwd_waddr[1] = 5'd7; fwd_waddr[2] = 5'd0;
    fwd_wdata[0] = 32'h11; fwd_wdata[1] = 32'h22; fwd_wdata[2] = 32'h99;
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h33;
    @(negedge clk);
    chk("prio_rdata1", out_rdata1, 32'h11);
    chk("prio_r0", out_rdata2, 32'h0);
    tick();
    fwd_we = '0; wb_we = 1'b0;

    // WB bypass, and the r7 write from the previous cycle landed
    set_inst(32'h404, 5'd9, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h77;
    @(negedge clk);
    chk("wb_bypass", out_rdata1, 32'h77);
    chk("rf_r7", out_rdata2, 32'h33);
    tick();
    wb_we = 1'b0;

    // Backpressure: 3 held cycles, then one transfer with refill
    out_ready = 1'b0;
    set_inst(32'h500, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
    in_valid = 1'b1;
    tick();
    set_inst(32'h504, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_pc_hold", out_pc, 32'h500);
      chk("bp_wa_hold", out_wr_addr, 5'd4);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 1'b1);
    chk("bp_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_pc", out_pc, 32'h504);
    tick();

    // Flush with a simultaneous fire while a load to r6 departs
    set_inst(32'h600, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1);
    in_valid = 1'b1;
    tick();
    set_inst(32'h604, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_inst(32'h608, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_pc", out_pc, 32'h0);
    chk("fl_inst", out_inst, 32'h0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_pend_stall", stallreq, 1'b1);
    tick();
    @(negedge clk);
    chk("fl_pend_done", out_valid, 1'b1);
    chk("fl_pend_data", out_rdata1, 32'hA000_0006);
    tick();

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
